// File: rtl/regfile_scoreboard_pkg.sv
// Register-map package: architectural register ids, widths and the helpers
// shared by the register file and its busy scoreboard.
package RegMap;

   typedef enum logic [7:0] {
      rax = 8'd0, rcx, rdx, rbx, rsp, rbp, rsi, rdi,
      r8, r9, r10, r11, r12, r13, r14, r15,
      rflags, rh0
   } reg_id_t;

   localparam int NREGS  = int'(rh0) + 1;
   localparam int DATA_W = 64;
   localparam int PEND_W = 2;
   localparam int IDX_W  = $clog2(NREGS);

   typedef logic [DATA_W-1:0] reg_data_t;
   typedef logic [PEND_W-1:0] pend_cnt_t;

   localparam pend_cnt_t PEND_MAX = '1;

   function automatic logic reg_id_legal(input reg_id_t id);
      return {24'd0, id} < NREGS;
   endfunction

endpackage

// File: rtl/regfile_scoreboard_pend_counter.sv
// Per-register pending-write counter: counts issued-but-unretired writes and
// never wraps in either direction.
module reg_pend_counter
   import RegMap::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              inc,
   input  logic              dec,
   output logic [PEND_W-1:0] count,
   output logic              busy,
   output logic              sat
);

   pend_cnt_t cnt;

   // Simultaneous inc and dec cancel; dec at zero is a stray writeback and is ignored.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (inc && !dec && cnt != PEND_MAX) begin
         cnt <= cnt + pend_cnt_t'(1);
      end else if (dec && !inc && cnt != '0) begin
         cnt <= cnt - pend_cnt_t'(1);
      end
   end

   assign count = cnt;
   assign busy  = (cnt != '0);
   assign sat   = (cnt == PEND_MAX);

endmodule

// File: rtl/regfile_scoreboard.sv
// Architectural register file with a per-register busy scoreboard: stalls
// issue on RAW hazards, returns operands one cycle later, forwards writeback.
module regfile_scoreboard
   import RegMap::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              iss_valid,
   output logic              iss_ready,
   input  logic              iss_src0_en,
   input  logic              iss_src1_en,
   input  logic [7:0]        iss_src0,
   input  logic [7:0]        iss_src1,
   input  logic              iss_dst_en,
   input  logic [7:0]        iss_dst,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data0,
   output logic [DATA_W-1:0] rd_data1,
   input  logic              wb_en,
   input  logic [7:0]        wb_id,
   input  logic [DATA_W-1:0] wb_data,
   output logic              err_id
);

   reg_data_t        regs [NREGS];
   pend_cnt_t        pend [NREGS];
   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] sat;
   logic [NREGS-1:0] inc;
   logic [NREGS-1:0] dec;

   logic             src0_legal, src1_legal, dst_legal, wb_legal;
   logic [IDX_W-1:0] src0_idx, src1_idx, dst_idx, wb_idx;
   logic             src0_hazard, src1_hazard, dst_stall;
   logic             accept, err_event;
   reg_data_t        src0_val, src1_val;

   assign src0_legal = reg_id_legal(reg_id_t'(iss_src0));
   assign src1_legal = reg_id_legal(reg_id_t'(iss_src1));
   assign dst_legal  = reg_id_legal(reg_id_t'(iss_dst));
   assign wb_legal   = reg_id_legal(reg_id_t'(wb_id));

   assign src0_idx = iss_src0[IDX_W-1:0];
   assign src1_idx = iss_src1[IDX_W-1:0];
   assign dst_idx  = iss_dst[IDX_W-1:0];
   assign wb_idx   = wb_id[IDX_W-1:0];

   // A writeback retiring the last outstanding write to a source clears its hazard this cycle.
   assign src0_hazard = iss_src0_en && src0_legal && busy[src0_idx] &&
                        !(wb_en && wb_id == iss_src0 && pend[src0_idx] == pend_cnt_t'(1));
   assign src1_hazard = iss_src1_en && src1_legal && busy[src1_idx] &&
                        !(wb_en && wb_id == iss_src1 && pend[src1_idx] == pend_cnt_t'(1));
   assign dst_stall   = iss_dst_en && dst_legal && sat[dst_idx] && !(wb_en && wb_id == iss_dst);

   assign iss_ready = !(src0_hazard || src1_hazard || dst_stall);
   assign accept    = iss_valid && iss_ready;

   assign err_event = (accept && ((iss_src0_en && !src0_legal) ||
                                  (iss_src1_en && !src1_legal) ||
                                  (iss_dst_en  && !dst_legal))) ||
                      (wb_en && !wb_legal);

   // Operand select: disabled or illegal sources read as zero, otherwise bypass beats the array.
   always_comb begin
      src0_val = '0;
      src1_val = '0;
      if (iss_src0_en && src0_legal) begin
         src0_val = (wb_en && wb_id == iss_src0) ? wb_data : regs[src0_idx];
      end
      if (iss_src1_en && src1_legal) begin
         src1_val = (wb_en && wb_id == iss_src1) ? wb_data : regs[src1_idx];
      end
   end

   for (genvar i = 0; i < NREGS; i++) begin : g_pend
      assign inc[i] = accept && iss_dst_en && dst_legal && dst_idx == IDX_W'(i);
      assign dec[i] = wb_en && wb_legal && wb_idx == IDX_W'(i);

      reg_pend_counter u_cnt (
         .clk   (clk),
         .reset (reset),
         .inc   (inc[i]),
         .dec   (dec[i]),
         .count (pend[i]),
         .busy  (busy[i]),
         .sat   (sat[i])
      );
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_en && wb_legal) begin
         regs[wb_idx] <= wb_data;
      end
   end

   // Operand data holds between accepts; the error flag is sticky until reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_valid <= 1'b0;
         rd_data0 <= '0;
         rd_data1 <= '0;
         err_id   <= 1'b0;
      end else begin
         rd_valid <= accept;
         if (accept) begin
            rd_data0 <= src0_val;
            rd_data1 <= src1_val;
         end
         if (err_event) begin
            err_id <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus random
// traffic, all checked against an id-indexed reference model.
module tb_regfile_scoreboard;

   logic        clk = 1'b0;
   logic        reset;
   logic        iss_valid, iss_ready;
   logic        iss_src0_en, iss_src1_en, iss_dst_en;
   logic [7:0]  iss_src0, iss_src1, iss_dst;
   logic        rd_valid;
   logic [63:0] rd_data0, rd_data1;
   logic        wb_en;
   logic [7:0]  wb_id;
   logic [63:0] wb_data;
   logic        err_id;

   int checks = 0;
   int fails  = 0;

   logic [63:0] m_regs [256];
   int          m_pend [256];
   bit          m_err;
   bit          exp_ready, exp_rd_valid;
   logic [63:0] exp_d0, exp_d1;

   regfile_scoreboard dut (
      .clk         (clk),
      .reset       (reset),
      .iss_valid   (iss_valid),
      .iss_ready   (iss_ready),
      .iss_src0_en (iss_src0_en),
      .iss_src1_en (iss_src1_en),
      .iss_src0    (iss_src0),
      .iss_src1    (iss_src1),
      .iss_dst_en  (iss_dst_en),
      .iss_dst     (iss_dst),
      .rd_valid    (rd_valid),
      .rd_data0    (rd_data0),
      .rd_data1    (rd_data1),
      .wb_en       (wb_en),
      .wb_id       (wb_id),
      .wb_data     (wb_data),
      .err_id      (err_id)
   );

   always #5 clk = ~clk;

   function automatic bit m_legal(input logic [7:0] id);
      return int'(id) < 18;
   endfunction

   function automatic logic [63:0] m_read(input logic en, input logic [7:0] id);
      if (!en || !m_legal(id)) return 64'd0;
      if (wb_en && wb_id == id) return wb_data;
      return m_regs[id];
   endfunction

   // A source waits while writes are outstanding, unless this writeback is the last one.
   function automatic bit model_ready();
      bit stall = 1'b0;
      if (iss_src0_en && m_legal(iss_src0) && m_pend[iss_src0] > 0 &&
          !(wb_en && wb_id == iss_src0 && m_pend[iss_src0] == 1)) stall = 1'b1;
      if (iss_src1_en && m_legal(iss_src1) && m_pend[iss_src1] > 0 &&
          !(wb_en && wb_id == iss_src1 && m_pend[iss_src1] == 1)) stall = 1'b1;
      if (iss_dst_en && m_legal(iss_dst) && m_pend[iss_dst] == 3 &&
          !(wb_en && wb_id == iss_dst)) stall = 1'b1;
      return !stall;
   endfunction

   function automatic void m_reset();
      for (int i = 0; i < 256; i++) begin
         m_regs[i] = 64'd0;
         m_pend[i] = 0;
      end
      m_err        = 1'b0;
      exp_rd_valid = 1'b0;
      exp_d0       = 64'd0;
      exp_d1       = 64'd0;
   endfunction

   task automatic drive(input logic v, input logic s0e, input logic [7:0] s0,
                        input logic s1e, input logic [7:0] s1,
                        input logic de, input logic [7:0] d,
                        input logic we, input logic [7:0] wi, input logic [63:0] wd);
      iss_valid   = v;
      iss_src0_en = s0e;
      iss_src0    = s0;
      iss_src1_en = s1e;
      iss_src1    = s1;
      iss_dst_en  = de;
      iss_dst     = d;
      wb_en       = we;
      wb_id       = wi;
      wb_data     = wd;
      exp_ready   = model_ready();
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 8'd0, 0, 8'd0, 0, 8'd0, 0, 8'd0, 64'd0);
   endtask

   // Advance one clock and move the model by the same edge.
   task automatic tick();
      bit acc;
      bit inc, dec;
      @(posedge clk);
      acc = iss_valid && exp_ready;
      exp_rd_valid = acc;
      if (acc) begin
         exp_d0 = m_read(iss_src0_en, iss_src0);
         exp_d1 = m_read(iss_src1_en, iss_src1);
         if ((iss_src0_en && !m_legal(iss_src0)) || (iss_src1_en && !m_legal(iss_src1)) ||
             (iss_dst_en && !m_legal(iss_dst))) m_err = 1'b1;
      end
      if (wb_en && !m_legal(wb_id)) m_err = 1'b1;
      for (int id = 0; id < 18; id++) begin
         inc = acc && iss_dst_en && int'(iss_dst) == id;
         dec = wb_en && int'(wb_id) == id;
         if (inc && !dec) m_pend[id] = m_pend[id] + 1;
         else if (dec && !inc && m_pend[id] > 0) m_pend[id] = m_pend[id] - 1;
      end
      if (wb_en && m_legal(wb_id)) m_regs[wb_id] = wb_data;
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      idle();
      m_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if (rd_valid !== 1'b0 || rd_data0 !== 64'd0 || rd_data1 !== 64'd0 || err_id !== 1'b0) begin
         fails++;
         $display("[TB] FAIL reset_outputs: got v=%0b d0=%h d1=%h err=%0b expected all zero",
                  rd_valid, rd_data0, rd_data1, err_id);
      end
      drive(1, 1, 8'd0, 1, 8'd1, 0, 8'd0, 0, 8'd0, 64'd0);
      checks++;
      if (iss_ready !== 1'b1) begin
         fails++;
         $display("[TB] FAIL reset_ready: got %0b expected 1", iss_ready);
      end
      tick();
      checks++;
      if (rd_valid !== 1'b1 || rd_data0 !== 64'd0 || rd_data1 !== 64'd0) begin
         fails++;
         $display("[TB] FAIL reset_read: got v=%0b d0=%h d1=%h expected v=1 d0=0 d1=0",
                  rd_valid, rd_data0, rd_data1);
      end
      idle();
      tick();
      checks++;
      if (rd_valid !== 1'b0) begin
         fails++;
         $display("[TB] FAIL rd_valid_pulse: got %0b expected 0", rd_valid);
      end
   endtask

   task automatic test_raw_bypass();
      drive(1, 0, 8'd0, 0, 8'd0, 1, 8'd3, 0, 8'd0, 64'd0);
      tick();
      for (int k = 0; k < 2; k++) begin
         drive(1, 1, 8'd3, 0, 8'd0, 0, 8'd0, 0, 8'd0, 64'd0);
         checks++;
         if (iss_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL raw_stall[%0d]: got %0b expected 0", k, iss_ready);
         end
         tick();
      end
      drive(1, 1, 8'd3, 0, 8'd0, 0, 8'd0, 1, 8'd3, 64'hDEAD_BEEF);
      checks++;
      if (iss_ready !== 1'b1) begin
         fails++;
         $display("[TB] FAIL raw_wb_release: got %0b expected 1", iss_ready);
      end
      tick();
      checks++;
      if (rd_valid !== 1'b1 || rd_data0 !== 64'hDEAD_BEEF) begin
         fails++;
         $display("[TB] FAIL raw_bypass_data: got v=%0b d0=%h expected v=1 d0=%h",
                  rd_valid, rd_data0, 64'hDEAD_BEEF);
      end
   endtask

   task automatic test_saturation();
      for (int k = 0; k < 4; k++) begin
         drive(1, 0, 8'd0, 0, 8'd0, 1, 8'd8, 0, 8'd0, 64'd0);
         checks++;
         if (iss_ready !== (k < 3)) begin
            fails++;
            $display("[TB] FAIL sat_issue[%0d]: got %0b expected %0b", k, iss_ready, k < 3);
         end
         tick();
      end
      drive(0, 0, 8'd0, 0, 8'd0, 0, 8'd0, 1, 8'd8, 64'h1111);
      tick();
      drive(1, 1, 8'd8, 0, 8'd0, 0, 8'd0, 0, 8'd0, 64'd0);
      checks++;
      if (iss_ready !== 1'b0) begin
         fails++;
         $display("[TB] FAIL sat_read_after_one_wb: got %0b expected 0", iss_ready);
      end
      tick();
      drive(0, 0, 8'd0, 0, 8'd0, 0, 8'd0, 1, 8'd8, 64'h2222);
      tick();
      drive(0, 0, 8'd0, 0, 8'd0, 0, 8'd0, 1, 8'd8, 64'h3333);
      tick();
      drive(1, 0, 8'd0, 1, 8'd8, 0, 8'd0, 0, 8'd0, 64'd0);
      tick();
      checks++;
      if (rd_valid !== 1'b1 || rd_data1 !== 64'h3333) begin
         fails++;
         $display("[TB] FAIL sat_drained_read: got v=%0b d1=%h expected v=1 d1=%h",
                  rd_valid, rd_data1, 64'h3333);
      end
   endtask

   task automatic test_same_cycle_issue_wb();
      drive(1, 0, 8'd0, 0, 8'd0, 1, 8'd2, 0, 8'd0, 64'd0);
      tick();
      drive(1, 0, 8'd0, 0, 8'd0, 1, 8'd2, 1, 8'd2, 64'd5);
      checks++;
      if (iss_ready !== 1'b1) begin
         fails++;
         $display("[TB] FAIL same_cycle_ready: got %0b expected 1", iss_ready);
      end
      tick();
      drive(1, 1, 8'd2, 0, 8'd0, 0, 8'd0, 0, 8'd0, 64'd0);
      checks++;
      if (iss_ready !== 1'b0) begin
         fails++;
         $display("[TB] FAIL same_cycle_still_busy: got %0b expected 0", iss_ready);
      end
      tick();
      drive(1, 1, 8'd2, 0, 8'd0, 0, 8'd0, 1, 8'd2, 64'd9);
      checks++;
      if (iss_ready !== 1'b1) begin
         fails++;
         $display("[TB] FAIL same_cycle_pend_one: got %0b expected 1", iss_ready);
      end
      tick();
      drive(1, 1, 8'd2, 0, 8'd0, 0, 8'd0, 0, 8'd0, 64'd0);
      tick();
      checks++;
      if (rd_valid !== 1'b1 || rd_data0 !== 64'd9) begin
         fails++;
         $display("[TB] FAIL same_cycle_final_value: got v=%0b d0=%h expected v=1 d0=9",
                  rd_valid, rd_data0);
      end
   endtask

   task automatic test_illegal_id();
      drive(0, 0, 8'd0, 0, 8'd0, 0, 8'd0, 1, 8'd200, 64'hBAD);
      tick();
      checks++;
      if (err_id !== 1'b1) begin
         fails++;
         $display("[TB] FAIL illegal_wb_err: got %0b expected 1", err_id);
      end
      drive(1, 1, 8'd200, 1, 8'd3, 0, 8'd0, 0, 8'd0, 64'd0);
      checks++;
      if (iss_ready !== 1'b1) begin
         fails++;
         $display("[TB] FAIL illegal_src_ready: got %0b expected 1", iss_ready);
      end
      tick();
      checks++;
      if (rd_data0 !== 64'd0 || rd_data1 !== 64'hDEAD_BEEF || err_id !== 1'b1) begin
         fails++;
         $display("[TB] FAIL illegal_src_read: got d0=%h d1=%h err=%0b expected d0=0 d1=%h err=1",
                  rd_data0, rd_data1, err_id, 64'hDEAD_BEEF);
      end
   endtask

   task automatic test_reset_midstream();
      drive(1, 0, 8'd0, 0, 8'd0, 1, 8'd6, 0, 8'd0, 64'd0);
      tick();
      drive(1, 1, 8'd2, 0, 8'd0, 1, 8'd6, 0, 8'd0, 64'd0);
      tick();
      reset = 1'b1;
      idle();
      m_reset();
      checks++;
      if (rd_valid !== 1'b0 || rd_data0 !== 64'd0 || rd_data1 !== 64'd0 || err_id !== 1'b0) begin
         fails++;
         $display("[TB] FAIL midstream_reset_outputs: got v=%0b d0=%h d1=%h err=%0b expected all zero",
                  rd_valid, rd_data0, rd_data1, err_id);
      end
      @(negedge clk);
      reset = 1'b0;
      drive(1, 1, 8'd6, 0, 8'd0, 0, 8'd0, 0, 8'd0, 64'd0);
      checks++;
      if (iss_ready !== 1'b1) begin
         fails++;
         $display("[TB] FAIL midstream_reset_rsi_ready: got %0b expected 1", iss_ready);
      end
      tick();
   endtask

   task automatic test_random();
      logic [7:0] ids [4];
      for (int n = 0; n < 400; n++) begin
         for (int j = 0; j < 4; j++) begin
            ids[j] = ($urandom_range(0, 15) == 0) ? 8'd200 : 8'($urandom_range(0, 17));
         end
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ids[0],
               1'($urandom_range(0, 1)), ids[1], 1'($urandom_range(0, 1)), ids[2],
               1'($urandom_range(0, 4) != 0), ids[3], {$urandom, $urandom});
         checks++;
         if (iss_ready !== exp_ready) begin
            fails++;
            $display("[TB] FAIL rand_ready[%0d]: got %0b expected %0b", n, iss_ready, exp_ready);
         end
         tick();
         checks++;
         if (rd_valid !== exp_rd_valid || rd_data0 !== exp_d0 || rd_data1 !== exp_d1 ||
             err_id !== m_err) begin
            fails++;
            $display("[TB] FAIL rand_outputs[%0d]: got v=%0b d0=%h d1=%h err=%0b expected v=%0b d0=%h d1=%h err=%0b",
                     n, rd_valid, rd_data0, rd_data1, err_id, exp_rd_valid, exp_d0, exp_d1, m_err);
         end
      end
   endtask

   initial begin
      apply_reset();
      test_reset();
      test_raw_bypass();
      test_saturation();
      test_same_cycle_issue_wb();
      test_illegal_id();
      test_reset_midstream();
      apply_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Architectural register file plus per-register busy scoreboard, indexed by the `RegMap::reg_id_t` register ids.
- Sits between decode (upstream, which produces register ids) and execute/writeback.
- Decode issues one instruction per cycle with up to two source operands and one destination. The block stalls issue on read-after-write hazards and returns operand data one cycle after an accepted issue.
- Writeback retires results, clears busy state and forwards the written value to a same-cycle issue.

Parameters:
- NREGS, 18, number of implemented registers; ids 0..NREGS-1 are legal (rax..r15, rflags, rh0).
- DATA_W, 64, register width in bits.
- PEND_W, 2, width of the per-register pending-write counter; maximum outstanding writes per register is 2^PEND_W-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- iss_valid  in  1  decode presents an instruction.
- iss_ready  out  1  combinational: the instruction can be accepted this cycle.
- iss_src0_en, iss_src1_en  in  1 each  source operand used.
- iss_src0, iss_src1  in  8 each  source register id (`reg_id_t`).
- iss_dst_en  in  1  instruction writes a destination.
- iss_dst  in  8  destination register id.
- rd_valid  out  1  operand data valid; asserted the cycle after an accepted issue.
- rd_data0, rd_data1  out  DATA_W each  operand values; zero when the matching src_en was 0.
- wb_en  in  1  writeback strobe.
- wb_id  in  8  writeback register id.
- wb_data  in  DATA_W  writeback value.
- err_id  out  1  sticky flag: an illegal id (>= NREGS) was used on an accepted issue or on a writeback.

Behaviour:
- Reset (asynchronous, dominates everything):
  - all registers = 0; all pending counters = 0.
  - rd_valid = 0, rd_data0/1 = 0, err_id = 0.
  - Reset mid-operation discards all outstanding busy state.
- Accept rule: accept = iss_valid & iss_ready.
- iss_ready = 1 unless any of the following holds:
  - an enabled source has pend[src] != 0 and the hazard is not cleared by a same-cycle writeback.
  - iss_dst_en=1 and pend[dst] is saturated (all ones) and there is no same-cycle writeback to dst.
- Same-cycle writeback clears a source hazard only when wb_en=1, wb_id==src and pend[src]==1.
- Read path, latency 1:
  - On accept, rd_dataN is registered from wb_data if (wb_en & wb_id==srcN), otherwise from the register array.
  - rd_valid = 1 for exactly one cycle per accept; otherwise rd_valid = 0 and rd_data holds its previous value.
- Writeback:
  - If wb_en=1 and wb_id is legal, the register is written and pend[wb_id] is decremented.
  - A writeback to a register with pend=0 still writes the data; the counter stays at 0 (no underflow).
- Issue destination: an accept with iss_dst_en=1 and a legal dst increments pend[dst].
- Same-cycle issue and writeback to the same id: net counter change is 0.
- Self-dependency (src == dst): the hazard check uses the counter value before this cycle's increment.
- Illegal ids (>= NREGS):
  - treated as never busy; reads return 0; writes and counter updates are dropped.
  - err_id is set and held until reset.
- State: no FSM beyond the counters. Each register is idle when pend==0 and busy when pend>0. The counter saturates at its maximum by stalling issue, never by wrapping.

Decomposition:
- Extend the shared `RegMap` package with:
  - NREGS, tied to the `rh0`+1 enum bound.
  - `reg_data_t` = logic[DATA_W-1:0].
  - `pend_cnt_t`.
  - a function `reg_id_legal(reg_id_t)`.
- One natural sub-module, `reg_pend_counter`: a per-register up/down saturating counter with inc, dec and busy outputs. It is instantiated NREGS times in the top block.
- The top block holds the data array, hazard logic, bypass mux and output registers.

Test Plan:
- Reset, then issue src0=rax, src1=rcx with iss_valid=1 -> iss_ready=1; the next cycle rd_valid=1 and rd_data0 = rd_data1 = 0.
- Issue dst=rbx (id 3); the next cycle issue src0=rbx -> iss_ready=0 and stays low. Drive wb_en=1, wb_id=3, wb_data=64'hDEAD_BEEF in the same cycle as the stalled issue -> iss_ready=1 and rd_data0 = 64'hDEAD_BEEF (bypass) one cycle later.
- Issue dst=r8 three times with no writeback -> the 4th issue to dst r8 stalls (pend=3). One wb to r8 -> pend=2, and a source read of r8 still stalls.
- Issue dst=rdx and wb rdx=5 in the same cycle while pend[rdx]=1 -> pend stays 1 and rdx=5.
- wb_id=8'd200 -> no register changes, err_id=1 and it stays 1. An issue with src0=200 -> iss_ready=1 and rd_data0=0.
- Set pend[rsi]=2, then assert reset mid-stream -> all outputs are 0. After release, issue src0=rsi -> iss_ready=1.
